// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: WIDTH-bit word out MSB-first on Q, each bit held BIT_CYCLES clocks.
// Define PISO_PARITY_EN to append one even-parity bit period after the data bits.
module piso_serializer #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] Din,
  input  logic             Load,
  output logic             Ready,
  output logic             Busy,
  output logic             Q,
  output logic             Done
);

  localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_PARITY = 2'd2} state_t;

  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1} state_t;
`endif

  state_t           state_r, state_s;
  logic [WIDTH-1:0] shreg_r, shreg_s;
  logic [CYC_W-1:0] cyc_r, cyc_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic             q_s, ready_s, busy_s, done_s;
`ifdef PISO_PARITY_EN
  logic             parity_r, parity_s;
`endif

  // State, datapath and registered outputs
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r  <= ST_IDLE;
      shreg_r  <= {WIDTH{1'b0}};
      cyc_r    <= {CYC_W{1'b0}};
      idx_r    <= {IDX_W{1'b0}};
`ifdef PISO_PARITY_EN
      parity_r <= 1'b0;
`endif
      Q        <= 1'b0;
      Ready    <= 1'b1;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      state_r  <= state_s;
      shreg_r  <= shreg_s;
      cyc_r    <= cyc_s;
      idx_r    <= idx_s;
`ifdef PISO_PARITY_EN
      parity_r <= parity_s;
`endif
      Q        <= q_s;
      Ready    <= ready_s;
      Busy     <= busy_s;
      Done     <= done_s;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_s  = state_r;
    shreg_s  = shreg_r;
    cyc_s    = cyc_r;
    idx_s    = idx_r;
`ifdef PISO_PARITY_EN
    parity_s = parity_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (Load) begin
          state_s  = ST_SHIFT;
          shreg_s  = Din;
          cyc_s    = {CYC_W{1'b0}};
          idx_s    = IDX_MSB;
`ifdef PISO_PARITY_EN
          parity_s = even_parity(Din);
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cyc_r == CYC_LAST) begin
          cyc_s = {CYC_W{1'b0}};
          if (idx_r == {IDX_W{1'b0}}) begin
`ifdef PISO_PARITY_EN
            state_s = ST_PARITY;
`else
            state_s = ST_IDLE;
`endif
          end else begin
            idx_s   = idx_r - IDX_W'(1);
            shreg_s = {shreg_r[WIDTH-2:0], 1'b0};
          end
        end else begin
          cyc_s = cyc_r + CYC_W'(1);
        end
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        if (cyc_r == CYC_LAST) begin
          cyc_s   = {CYC_W{1'b0}};
          state_s = ST_IDLE;
        end else begin
          cyc_s = cyc_r + CYC_W'(1);
        end
      end
`endif
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state
  always_comb begin
    q_s     = 1'b0;
    ready_s = (state_s == ST_IDLE);
    busy_s  = (state_s != ST_IDLE);
    done_s  = (state_r != ST_IDLE) && (state_s == ST_IDLE);
    case (state_s)
      ST_IDLE:   q_s = 1'b0;
      ST_SHIFT:  q_s = shreg_s[WIDTH-1];
`ifdef PISO_PARITY_EN
      ST_PARITY: q_s = parity_s;
`endif
      default:   q_s = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: a BIT_CYCLES=1 instance and a BIT_CYCLES=3 instance.
// Build with PISO_PARITY_EN defined to also check the parity bit period.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din1 = 8'h00, din3 = 8'h00;
  logic       load1 = 1'b0, load3 = 1'b0;
  logic       ready1, busy1, q1, done1;
  logic       ready3, busy3, q3, done3;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .BIT_CYCLES(1)) u_dut1 (
    .Clk(clk), .Rst(rst), .Din(din1), .Load(load1),
    .Ready(ready1), .Busy(busy1), .Q(q1), .Done(done1)
  );

  piso_serializer #(.WIDTH(8), .BIT_CYCLES(3)) u_dut3 (
    .Clk(clk), .Rst(rst), .Din(din3), .Load(load3),
    .Ready(ready3), .Busy(busy3), .Q(q3), .Done(done3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected vectors below are {Q, Busy, Ready, Done}
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({q1, busy1, ready1, done1} !== 4'b0010) begin
      bad++;
      $display("FAIL reset_dut1 got=%b want=0010", {q1, busy1, ready1, done1});
    end
    total++;
    if ({q3, busy3, ready3, done3} !== 4'b0010) begin
      bad++;
      $display("FAIL reset_dut3 got=%b want=0010", {q3, busy3, ready3, done3});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] v;
    v = 8'hA5;
    din1 = v; load1 = 1'b1;
    tick();
    load1 = 1'b0; din1 = 8'h00;
    for (int k = 0; k < 8; k++) begin
      total++;
      if ({q1, busy1, ready1, done1} !== {v[7-k], 3'b100}) begin
        bad++;
        $display("FAIL basic_bit%0d got=%b want=%b", k, {q1, busy1, ready1, done1}, {v[7-k], 3'b100});
      end
      tick();
    end
`ifdef PISO_PARITY_EN
    total++;
    if ({q1, busy1, ready1, done1} !== 4'b0100) begin
      bad++;
      $display("FAIL basic_parity got=%b want=0100", {q1, busy1, ready1, done1});
    end
    tick();
`endif
    total++;
    if ({q1, busy1, ready1, done1} !== 4'b0011) begin
      bad++;
      $display("FAIL basic_done got=%b want=0011", {q1, busy1, ready1, done1});
    end
    tick();
    total++;
    if ({q1, busy1, ready1, done1} !== 4'b0010) begin
      bad++;
      $display("FAIL basic_idle got=%b want=0010", {q1, busy1, ready1, done1});
    end
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity_odd();
    logic [7:0] v;
    v = 8'h07;
    din1 = v; load1 = 1'b1;
    tick();
    load1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (q1 !== v[7-k]) begin
        bad++;
        $display("FAIL par07_bit%0d got=%b want=%b", k, q1, v[7-k]);
      end
      tick();
    end
    total++;
    if ({q1, busy1, ready1, done1} !== 4'b1100) begin
      bad++;
      $display("FAIL par07_parity got=%b want=1100", {q1, busy1, ready1, done1});
    end
    tick();
    total++;
    if ({q1, busy1, ready1, done1} !== 4'b0011) begin
      bad++;
      $display("FAIL par07_done got=%b want=0011", {q1, busy1, ready1, done1});
    end
    tick();
  endtask
`endif

  task automatic test_slow();
    logic [7:0] v;
    v = 8'h81;
    din3 = v; load3 = 1'b1;
    tick();
    load3 = 1'b0; din3 = 8'h00;
    for (int k = 0; k < 24; k++) begin
      total++;
      if ({q3, busy3, ready3, done3} !== {v[7-(k/3)], 3'b100}) begin
        bad++;
        $display("FAIL slow_cyc%0d got=%b want=%b", k, {q3, busy3, ready3, done3}, {v[7-(k/3)], 3'b100});
      end
      tick();
    end
`ifdef PISO_PARITY_EN
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({q3, busy3, ready3, done3} !== 4'b0100) begin
        bad++;
        $display("FAIL slow_parity%0d got=%b want=0100", k, {q3, busy3, ready3, done3});
      end
      tick();
    end
`endif
    total++;
    if ({q3, busy3, ready3, done3} !== 4'b0011) begin
      bad++;
      $display("FAIL slow_done got=%b want=0011", {q3, busy3, ready3, done3});
    end
    tick();
    total++;
    if ({q3, busy3, ready3, done3} !== 4'b0010) begin
      bad++;
      $display("FAIL slow_idle got=%b want=0010", {q3, busy3, ready3, done3});
    end
  endtask

  task automatic test_ignore_load();
    logic [7:0] v;
    int ndone, nbusy;
    v = 8'h3C; ndone = 0; nbusy = 0;
    din1 = v; load1 = 1'b1;
    tick();
    load1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (q1 !== v[7-k]) begin
        bad++;
        $display("FAIL ign_bit%0d got=%b want=%b", k, q1, v[7-k]);
      end
      if (done1) ndone++;
      // mid-frame Load with new data must be dropped
      if (k == 3) begin
        load1 = 1'b1; din1 = 8'hFF;
      end else begin
        load1 = 1'b0;
      end
      tick();
    end
`ifdef PISO_PARITY_EN
    if (done1) ndone++;
    tick();
`endif
    for (int k = 0; k < 12; k++) begin
      if (done1) ndone++;
      if (busy1) nbusy++;
      tick();
    end
    total++;
    if (ndone !== 1) begin
      bad++;
      $display("FAIL ign_done_count got=%0d want=1", ndone);
    end
    total++;
    if (nbusy !== 0) begin
      bad++;
      $display("FAIL ign_busy_after got=%0d want=0", nbusy);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    int ndone;
    v = 8'hF0; ndone = 0;
    din1 = v; load1 = 1'b1;
    tick();
    load1 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (q1 !== v[7-k]) begin
        bad++;
        $display("FAIL rstmid_bit%0d got=%b want=%b", k, q1, v[7-k]);
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({q1, busy1, ready1, done1} !== 4'b0010) begin
      bad++;
      $display("FAIL rstmid_abort got=%b want=0010", {q1, busy1, ready1, done1});
    end
    for (int k = 0; k < 10; k++) begin
      if (done1) ndone++;
      tick();
    end
    total++;
    if (ndone !== 0) begin
      bad++;
      $display("FAIL rstmid_no_done got=%0d want=0", ndone);
    end
    v = 8'h01;
    din1 = v; load1 = 1'b1;
    tick();
    load1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      total++;
      if ({q1, busy1} !== {v[7-k], 1'b1}) begin
        bad++;
        $display("FAIL rstmid_next_bit%0d got=%b want=%b", k, {q1, busy1}, {v[7-k], 1'b1});
      end
      tick();
    end
`ifdef PISO_PARITY_EN
    total++;
    if (q1 !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_next_parity got=%b want=1", q1);
    end
    tick();
`endif
    total++;
    if ({q1, busy1, ready1, done1} !== 4'b0011) begin
      bad++;
      $display("FAIL rstmid_next_done got=%b want=0011", {q1, busy1, ready1, done1});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    v = 8'h55;
    din1 = v; load1 = 1'b1;
    tick();
    din1 = 8'hAA;
    for (int k = 0; k < 8; k++) begin
      total++;
      if ({q1, busy1} !== {v[7-k], 1'b1}) begin
        bad++;
        $display("FAIL b2b_a_bit%0d got=%b want=%b", k, {q1, busy1}, {v[7-k], 1'b1});
      end
      tick();
    end
`ifdef PISO_PARITY_EN
    tick();
`endif
    total++;
    if ({q1, busy1, ready1, done1} !== 4'b0011) begin
      bad++;
      $display("FAIL b2b_gap got=%b want=0011", {q1, busy1, ready1, done1});
    end
    tick();
    load1 = 1'b0;
    v = 8'hAA;
    for (int k = 0; k < 8; k++) begin
      total++;
      if ({q1, busy1, done1} !== {v[7-k], 2'b10}) begin
        bad++;
        $display("FAIL b2b_b_bit%0d got=%b want=%b", k, {q1, busy1, done1}, {v[7-k], 2'b10});
      end
      tick();
    end
`ifdef PISO_PARITY_EN
    tick();
`endif
    total++;
    if ({q1, busy1, ready1, done1} !== 4'b0011) begin
      bad++;
      $display("FAIL b2b_b_done got=%b want=0011", {q1, busy1, ready1, done1});
    end
    tick();
  endtask

  initial begin
    tick();
    test_reset();
    test_basic();
`ifdef PISO_PARITY_EN
    test_parity_odd();
`endif
    test_slow();
    test_ignore_load();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
